// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: register address width, operand-select encodings,
// shadow-stage record types and the destination-match helper.
package pipe_pkg;

   localparam int REG_AW = 5;
   localparam int NREGS  = 32;

   typedef logic [REG_AW-1:0] reg_addr_t;
   typedef logic [1:0]        fwd_sel_t;

   localparam fwd_sel_t FWD_RF  = 2'd0;
   localparam fwd_sel_t FWD_WB  = 2'd1;
   localparam fwd_sel_t FWD_MEM = 2'd2;

   typedef struct packed {
      reg_addr_t rs;
      reg_addr_t rt;
      reg_addr_t rd;
      logic      regwrite;
      logic      memread;
   } ex_stage_t;

   typedef struct packed {
      reg_addr_t rd;
      logic      regwrite;
   } wr_stage_t;

   localparam ex_stage_t EX_BUBBLE = '0;
   localparam wr_stage_t WR_EMPTY  = '0;

   // Register 0 is hard-wired zero, so a zero destination never matches.
   function automatic logic dest_hits(input reg_addr_t dest, input logic we,
                                      input reg_addr_t src);
      return we && (dest != '0) && (dest == src);
   endfunction

endpackage

// File: rtl/fwd_sel_cmp.sv
// Priority compare of one EX source register against the MEM and WB destinations.
// The younger MEM result wins over WB when both write the same register.
module fwd_sel_cmp
   import pipe_pkg::*;
(
   input  logic [REG_AW-1:0] src,
   input  logic [REG_AW-1:0] mem_rd,
   input  logic              mem_regwrite,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic              wb_regwrite,
   output logic [1:0]        sel
);

   always_comb begin
      sel = FWD_RF;
      if (dest_hits(mem_rd, mem_regwrite, src)) begin
         sel = FWD_MEM;
      end else if (dest_hits(wb_rd, wb_regwrite, src)) begin
         sel = FWD_WB;
      end
   end

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding and load-use hazard control with an EX/MEM/WB shadow pipeline.
// Define HAZ_PERF_CNT_EN to add the saturating stall_cnt counter and its cnt_clr input.
module fwd_hazard_ctrl
   import pipe_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              flush,
`ifdef HAZ_PERF_CNT_EN
   input  logic              cnt_clr,
   output logic [31:0]       stall_cnt,
`endif
   output logic [1:0]        fwd_a_sel,
   output logic [1:0]        fwd_b_sel,
   output logic              stall,
   output logic [REG_AW-1:0] ex_rd_o
);

   ex_stage_t ex_reg;
   ex_stage_t ex_next;
   wr_stage_t mem_reg;
   wr_stage_t wb_reg;

   // A load in EX whose result the ID instruction needs cannot be forwarded in time.
   always_comb begin
      stall = ex_reg.memread
              && (ex_reg.rd != '0)
              && ((ex_reg.rd == id_rs) || (ex_reg.rd == id_rt));
   end

   always_comb begin
      ex_next = EX_BUBBLE;
      if (!(stall || flush)) begin
         ex_next.rs       = id_rs;
         ex_next.rt       = id_rt;
         ex_next.rd       = id_rd;
         ex_next.regwrite = id_regwrite;
         ex_next.memread  = id_memread;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_reg  <= EX_BUBBLE;
         mem_reg <= WR_EMPTY;
         wb_reg  <= WR_EMPTY;
      end else begin
         ex_reg           <= ex_next;
         mem_reg.rd       <= ex_reg.rd;
         mem_reg.regwrite <= ex_reg.regwrite;
         wb_reg           <= mem_reg;
      end
   end

   reg_addr_t src [2];
   fwd_sel_t  sel [2];

   assign src[0] = ex_reg.rs;
   assign src[1] = ex_reg.rt;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_opnd
         fwd_sel_cmp u_cmp (
            .src          (src[gi]),
            .mem_rd       (mem_reg.rd),
            .mem_regwrite (mem_reg.regwrite),
            .wb_rd        (wb_reg.rd),
            .wb_regwrite  (wb_reg.regwrite),
            .sel          (sel[gi])
         );
      end
   endgenerate

   assign fwd_a_sel = sel[0];
   assign fwd_b_sel = sel[1];
   assign ex_rd_o   = ex_reg.rd;

`ifdef HAZ_PERF_CNT_EN
   logic [31:0] cnt_reg;

   // Clear wins over a coincident stall; the count sticks at all-ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg <= '0;
      end else if (cnt_clr) begin
         cnt_reg <= '0;
      end else if (stall && (cnt_reg != 32'hFFFF_FFFF)) begin
         cnt_reg <= cnt_reg + 32'd1;
      end
   end

   assign stall_cnt = cnt_reg;
`endif

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Directed bench for fwd_hazard_ctrl; expected values are hand-derived from the pipeline timing.
// Build with +define+HAZ_PERF_CNT_EN to also exercise the stall counter.
module tb_fwd_hazard_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0;
   logic       id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
   logic       cnt_clr = 1'b0;
   logic [1:0] fwd_a_sel, fwd_b_sel;
   logic       stall;
   logic [4:0] ex_rd_o;
`ifdef HAZ_PERF_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fwd_hazard_ctrl dut (
      .clk         (clk),
      .rst         (rst),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_rd       (id_rd),
      .id_regwrite (id_regwrite),
      .id_memread  (id_memread),
      .flush       (flush),
`ifdef HAZ_PERF_CNT_EN
      .cnt_clr     (cnt_clr),
      .stall_cnt   (stall_cnt),
`endif
      .fwd_a_sel   (fwd_a_sel),
      .fwd_b_sel   (fwd_b_sel),
      .stall       (stall),
      .ex_rd_o     (ex_rd_o)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Drive one ID instruction just after the falling edge; outputs are checked before the next rise.
   task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic rw, input logic mr, input logic fl);
      @(negedge clk);
      id_rs = rs; id_rt = rt; id_rd = rd;
      id_regwrite = rw; id_memread = mr; flush = fl;
      #1;
      $display("id rs=%0d rt=%0d rd=%0d rw=%0b mr=%0b fl=%0b | ex_rd=%0d a=%0d b=%0d stall=%0b",
               rs, rt, rd, rw, mr, fl, ex_rd_o, fwd_a_sel, fwd_b_sel, stall);
   endtask

   task automatic nops(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         check("a_not3", {31'd0, fwd_a_sel == 2'd3}, 32'd0);
         check("b_not3", {31'd0, fwd_b_sel == 2'd3}, 32'd0);
      end
   end

   initial begin
      #2;
      check("rst_a", fwd_a_sel, 0);
      check("rst_b", fwd_b_sel, 0);
      check("rst_stall", stall, 0);
      check("rst_exrd", ex_rd_o, 0);
      @(negedge clk);
      rst = 1'b0;

      // ALU back-to-back
      step(1, 2, 3, 1, 0, 0);
      step(3, 4, 6, 1, 0, 0);
      nops(1);
      check("b2b_a", fwd_a_sel, 2);
      check("b2b_b", fwd_b_sel, 0);
      check("b2b_stall", stall, 0);
      check("b2b_exrd", ex_rd_o, 6);
      nops(3);

      // distance 2
      step(1, 2, 5, 1, 0, 0);
      step(1, 2, 8, 1, 0, 0);
      step(9, 5, 10, 1, 0, 0);
      nops(1);
      check("d2_b", fwd_b_sel, 1);
      check("d2_a", fwd_a_sel, 0);
      nops(3);
      step(1, 2, 5, 1, 0, 0);
      step(1, 2, 5, 1, 0, 0);
      step(9, 5, 10, 1, 0, 0);
      nops(1);
      check("d12_b", fwd_b_sel, 2);
      nops(3);

      // load-use
      step(1, 0, 7, 1, 1, 0);
      step(7, 2, 11, 1, 0, 0);
      check("lu_stall", stall, 1);
      step(7, 2, 11, 1, 0, 0);
      check("lu_stall_off", stall, 0);
      check("lu_bubble_a", fwd_a_sel, 0);
      check("lu_bubble_rd", ex_rd_o, 0);
      nops(1);
      check("lu_cons_a", fwd_a_sel, 1);
      check("lu_cons_rd", ex_rd_o, 11);
      nops(3);

      // register 0
      step(1, 2, 0, 1, 0, 0);
      step(0, 0, 12, 1, 0, 0);
      nops(1);
      check("r0_a", fwd_a_sel, 0);
      check("r0_b", fwd_b_sel, 0);
      step(1, 2, 0, 1, 1, 0);
      step(0, 0, 12, 1, 0, 0);
      check("r0_ld_stall", stall, 0);
      nops(3);

      // flush
      step(1, 2, 4, 1, 0, 1);
      step(4, 0, 13, 1, 0, 0);
      check("fl_exrd", ex_rd_o, 0);
      nops(1);
      check("fl_a", fwd_a_sel, 0);
      nops(3);

      // asynchronous reset mid-stream
      step(1, 2, 13, 1, 0, 0);
      step(13, 0, 14, 1, 1, 0);
      step(14, 13, 15, 1, 0, 0);
      check("pre_rst_a", fwd_a_sel, 2);
      check("pre_rst_stall", stall, 1);
      check("pre_rst_exrd", ex_rd_o, 14);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_a", fwd_a_sel, 0);
      check("mid_rst_b", fwd_b_sel, 0);
      check("mid_rst_stall", stall, 0);
      check("mid_rst_exrd", ex_rd_o, 0);
      @(negedge clk);
      rst = 1'b0;
      step(14, 13, 15, 1, 0, 0);
      check("post_rst_stall", stall, 0);
      nops(1);
      check("post_rst_a", fwd_a_sel, 0);
      nops(3);

`ifdef HAZ_PERF_CNT_EN
      @(negedge clk);
      cnt_clr = 1'b1;
      @(negedge clk);
      cnt_clr = 1'b0;
      check("cnt_clr0", stall_cnt, 0);
      for (int k = 0; k < 3; k++) begin
         step(1, 0, 7, 1, 1, 0);
         step(0, 7, 11, 1, 0, 0);
         step(0, 7, 11, 1, 0, 0);
         nops(1);
      end
      check("cnt_three", stall_cnt, 3);
      step(1, 0, 9, 1, 1, 0);
      step(9, 0, 11, 1, 0, 0);
      cnt_clr = 1'b1;
      check("cnt_clr_stall", stall, 1);
      step(9, 0, 11, 1, 0, 0);
      cnt_clr = 1'b0;
      check("cnt_clr_prio", stall_cnt, 0);
      nops(2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
